// File: rtl/sync_edge_filter.sv
// Multi-channel synchronizer with per-channel glitch filter, registered edge pulses
// and sticky event flags with per-channel clear.
module sync_edge_filter #(
  parameter int CHANNELS      = 4,
  parameter int SYNC_STAGES   = 2,
  parameter int FILTER_CYCLES = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [CHANNELS-1:0] in,
  input  logic [CHANNELS-1:0] clear,
  output logic [CHANNELS-1:0] level,
  output logic [CHANNELS-1:0] rising_edge,
  output logic [CHANNELS-1:0] falling_edge,
  output logic [CHANNELS-1:0] sticky_rise,
  output logic [CHANNELS-1:0] sticky_fall,
  output logic                any_event
);

  localparam int CntW = (FILTER_CYCLES > 1) ? $clog2(FILTER_CYCLES) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(FILTER_CYCLES - 1);

  logic [SYNC_STAGES-1:0][CHANNELS-1:0] syncChain_q;
  logic [CHANNELS-1:0][CntW-1:0]        cnt_q, cnt_d;
  logic [CHANNELS-1:0]                  level_q, level_d;
  logic [CHANNELS-1:0]                  rise_q, rise_d;
  logic [CHANNELS-1:0]                  fall_q, fall_d;
  logic [CHANNELS-1:0]                  stickyRise_q, stickyRise_d;
  logic [CHANNELS-1:0]                  stickyFall_q, stickyFall_d;
  logic [CHANNELS-1:0]                  synced;

  assign synced = syncChain_q[SYNC_STAGES-1];

  // Filter: a new level is accepted only after FILTER_CYCLES consecutive disagreeing samples.
  always_comb begin
    level_d = level_q;
    cnt_d   = cnt_q;
    rise_d  = '0;
    fall_d  = '0;
    for (int ch = 0; ch < CHANNELS; ch++) begin
      if (synced[ch] == level_q[ch]) begin
        cnt_d[ch] = '0;
      end else if (cnt_q[ch] == CntMax) begin
        level_d[ch] = synced[ch];
        cnt_d[ch]   = '0;
        rise_d[ch]  = synced[ch];
        fall_d[ch]  = ~synced[ch];
      end else begin
        cnt_d[ch] = cnt_q[ch] + CntW'(1);
      end
    end
  end

  // An event registering on the same edge as a clear survives the clear.
  assign stickyRise_d = rise_d | (stickyRise_q & ~clear);
  assign stickyFall_d = fall_d | (stickyFall_q & ~clear);

  always_ff @(posedge clk) begin
    if (reset) begin
      syncChain_q  <= '0;
      cnt_q        <= '0;
      level_q      <= '0;
      rise_q       <= '0;
      fall_q       <= '0;
      stickyRise_q <= '0;
      stickyFall_q <= '0;
    end else begin
      syncChain_q  <= {syncChain_q[SYNC_STAGES-2:0], in};
      cnt_q        <= cnt_d;
      level_q      <= level_d;
      rise_q       <= rise_d;
      fall_q       <= fall_d;
      stickyRise_q <= stickyRise_d;
      stickyFall_q <= stickyFall_d;
    end
  end

  assign level        = level_q;
  assign rising_edge  = rise_q;
  assign falling_edge = fall_q;
  assign sticky_rise  = stickyRise_q;
  assign sticky_fall  = stickyFall_q;
  assign any_event    = |{stickyRise_q, stickyFall_q};

endmodule

// File: tb/tb_sync_edge_filter.sv
// Directed and scoreboard checks for sync_edge_filter across three parameter sets:
// defaults, FILTER_CYCLES=4, and CHANNELS=8 with FILTER_CYCLES=8.
module tb_sync_edge_filter;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  logic [3:0] inA, clearA, levelA, riseA, fallA, srA, sfA;
  logic       anyA;
  logic [3:0] in4, clear4, level4, rise4, fall4, sr4, sf4;
  logic       any4;
  logic [7:0] in8, clear8, level8, rise8, fall8, sr8, sf8;
  logic       any8;

  sync_edge_filter #(.CHANNELS(4), .SYNC_STAGES(2), .FILTER_CYCLES(1)) dutA (
    .clk(clk), .reset(reset), .in(inA), .clear(clearA), .level(levelA),
    .rising_edge(riseA), .falling_edge(fallA), .sticky_rise(srA),
    .sticky_fall(sfA), .any_event(anyA));

  sync_edge_filter #(.CHANNELS(4), .SYNC_STAGES(2), .FILTER_CYCLES(4)) dut4 (
    .clk(clk), .reset(reset), .in(in4), .clear(clear4), .level(level4),
    .rising_edge(rise4), .falling_edge(fall4), .sticky_rise(sr4),
    .sticky_fall(sf4), .any_event(any4));

  sync_edge_filter #(.CHANNELS(8), .SYNC_STAGES(2), .FILTER_CYCLES(8)) dut8 (
    .clk(clk), .reset(reset), .in(in8), .clear(clear8), .level(level8),
    .rising_edge(rise8), .falling_edge(fall8), .sticky_rise(sr8),
    .sticky_fall(sf8), .any_event(any8));

  // Advance one active edge; inputs driven and outputs sampled 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    $display("[TB] test_reset");
    reset = 1'b1;
    inA = 4'hF; clearA = '0; in4 = '0; clear4 = '0; in8 = '0; clear8 = '0;
    for (int c = 0; c < 3; c++) begin
      step();
      checks++;
      if ({levelA, riseA, fallA, srA, sfA, anyA} !== 21'd0) begin
        errors++;
        $display("[TB] FAIL reset_outputs cycle %0d got %h want 0", c,
                 {levelA, riseA, fallA, srA, sfA, anyA});
      end
    end
    reset = 1'b0;
    for (int e = 1; e <= 4; e++) begin
      step();
      checks++;
      if (riseA !== ((e == 3) ? 4'hF : 4'h0)) begin
        errors++;
        $display("[TB] FAIL reset_rise edge %0d got %h want %h", e, riseA, (e == 3) ? 4'hF : 4'h0);
      end
      checks++;
      if (levelA !== ((e >= 3) ? 4'hF : 4'h0)) begin
        errors++;
        $display("[TB] FAIL reset_level edge %0d got %h", e, levelA);
      end
    end
    checks++;
    if (srA !== 4'hF || sfA !== 4'h0 || anyA !== 1'b1) begin
      errors++;
      $display("[TB] FAIL reset_sticky got sr=%h sf=%h any=%b want sr=f sf=0 any=1", srA, sfA, anyA);
    end
  endtask

  task automatic test_toggle();
    logic [3:0] expRise, expFall;
    $display("[TB] test_toggle");
    for (int c = 0; c < 12; c++) begin
      if (c < 10) inA[2] = (c % 2 == 1);
      step();
      expRise = '0;
      expFall = '0;
      if (c >= 2) begin
        if ((c - 2) % 2 == 0) expFall[2] = 1'b1;
        else                  expRise[2] = 1'b1;
      end
      checks++;
      if (riseA !== expRise || fallA !== expFall) begin
        errors++;
        $display("[TB] FAIL toggle_pulse c=%0d got r=%h f=%h want r=%h f=%h",
                 c, riseA, fallA, expRise, expFall);
      end
      checks++;
      if ((riseA & fallA) !== 4'h0) begin
        errors++;
        $display("[TB] FAIL toggle_exclusive c=%0d got %h want 0", c, riseA & fallA);
      end
    end
  endtask

  task automatic test_sticky();
    $display("[TB] test_sticky");
    clearA = 4'hF;
    step();
    clearA = '0;
    checks++;
    if (srA !== 4'h0 || sfA !== 4'h0 || anyA !== 1'b0) begin
      errors++;
      $display("[TB] FAIL sticky_clear_all got sr=%h sf=%h any=%b want 0", srA, sfA, anyA);
    end
    inA[1] = 1'b0;
    step();
    step();
    clearA[1] = 1'b1;
    step();
    checks++;
    if (fallA !== 4'b0010 || sfA !== 4'b0010) begin
      errors++;
      $display("[TB] FAIL sticky_set_wins got fall=%h sf=%h want 2 2", fallA, sfA);
    end
    step();
    clearA = '0;
    checks++;
    if (sfA !== 4'h0 || anyA !== 1'b0) begin
      errors++;
      $display("[TB] FAIL sticky_cleared got sf=%h any=%b want 0 0", sfA, anyA);
    end
  endtask

  task automatic test_glitch();
    $display("[TB] test_glitch");
    reset = 1'b1; in4 = '0; clear4 = '0;
    step();
    reset = 1'b0;
    step();
    for (int g = 0; g < 3; g++) begin
      for (int c = 0; c < 6; c++) begin
        in4[0] = (c < 3);
        step();
        checks++;
        if (rise4 !== 4'h0 || level4 !== 4'h0) begin
          errors++;
          $display("[TB] FAIL glitch_reject g=%0d c=%0d got r=%h lvl=%h want 0 0", g, c, rise4, level4);
        end
      end
    end
    for (int c = 0; c < 11; c++) begin
      in4[0] = (c < 4);
      step();
      checks++;
      if (rise4 !== ((c == 5) ? 4'h1 : 4'h0) || fall4 !== ((c == 9) ? 4'h1 : 4'h0)) begin
        errors++;
        $display("[TB] FAIL glitch_accept c=%0d got r=%h f=%h", c, rise4, fall4);
      end
      checks++;
      if (level4 !== ((c >= 5 && c < 9) ? 4'h1 : 4'h0)) begin
        errors++;
        $display("[TB] FAIL glitch_level c=%0d got %h", c, level4);
      end
    end
  endtask

  task automatic test_reset_mid();
    $display("[TB] test_reset_mid");
    reset = 1'b1; in8 = '0; clear8 = '0;
    step();
    reset = 1'b0;
    in8[3] = 1'b1;
    for (int e = 1; e <= 7; e++) begin
      step();
      checks++;
      if (rise8 !== 8'h00) begin
        errors++;
        $display("[TB] FAIL mid_pre e=%0d got %h want 0", e, rise8);
      end
    end
    reset = 1'b1;
    step();
    reset = 1'b0;
    checks++;
    if ({level8, rise8, sr8} !== 24'd0) begin
      errors++;
      $display("[TB] FAIL mid_reset got %h want 0", {level8, rise8, sr8});
    end
    for (int e = 1; e <= 11; e++) begin
      step();
      checks++;
      if (rise8 !== ((e == 10) ? 8'h08 : 8'h00) || level8 !== ((e >= 10) ? 8'h08 : 8'h00)) begin
        errors++;
        $display("[TB] FAIL mid_after e=%0d got r=%h lvl=%h", e, rise8, level8);
      end
    end
  endtask

  task automatic test_independence();
    logic [7:0] mS0, mS1, mL, mRise, mFall, mSr, mSf, s;
    int mCnt [8];
    $display("[TB] test_independence");
    reset = 1'b1; in8 = '0; clear8 = '0;
    step();
    reset = 1'b0;
    mS0 = '0; mS1 = '0; mL = '0; mSr = '0; mSf = '0;
    for (int ch = 0; ch < 8; ch++) mCnt[ch] = 0;
    for (int c = 0; c < 300; c++) begin
      for (int ch = 0; ch < 8; ch++) begin
        if ($urandom_range(5) == 0) in8[ch] = ~in8[ch];
        clear8[ch] = ($urandom_range(7) == 0);
      end
      s = mS1; mS1 = mS0; mS0 = in8;
      mRise = '0; mFall = '0;
      for (int ch = 0; ch < 8; ch++) begin
        if (s[ch] == mL[ch]) mCnt[ch] = 0;
        else if (mCnt[ch] == 7) begin
          mL[ch] = s[ch]; mCnt[ch] = 0;
          if (s[ch]) mRise[ch] = 1'b1; else mFall[ch] = 1'b1;
        end else mCnt[ch] = mCnt[ch] + 1;
      end
      mSr = mRise | (mSr & ~clear8);
      mSf = mFall | (mSf & ~clear8);
      step();
      checks++;
      if (level8 !== mL || rise8 !== mRise || fall8 !== mFall) begin
        errors++;
        $display("[TB] FAIL indep_pulse c=%0d got l=%h r=%h f=%h want l=%h r=%h f=%h",
                 c, level8, rise8, fall8, mL, mRise, mFall);
      end
      checks++;
      if (sr8 !== mSr || sf8 !== mSf || any8 !== |{mSr, mSf}) begin
        errors++;
        $display("[TB] FAIL indep_sticky c=%0d got sr=%h sf=%h any=%b want sr=%h sf=%h",
                 c, sr8, sf8, any8, mSr, mSf);
      end
    end
  endtask

  initial begin
    test_reset();
    test_toggle();
    test_sticky();
    test_glitch();
    test_reset_mid();
    test_independence();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
